// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO stack: push/pop op-code and
// a helper that sizes the occupancy counter from the stack depth.
package lifo_pkg;

    // Op-code taken straight from the {push, pop} strobe pair.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } lifo_op_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// combinational read port. Addresses share the occupancy counter width so
// the stack pointer can drive them directly.
module lifo_mem #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write; out-of-range addresses are ignored.
    // NOTE: storage is deliberately not reset; the pointer alone defines which
    // entries are live, and leaving the array reset-free lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read of the addressed entry; out-of-range reads return 0.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO stack with separate push/pop strobes,
// occupancy count, sticky overflow/underflow flags and a read-valid strobe.
module lifo_stack_param
    import lifo_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = calc_cnt_w(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EN,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              valid,
    output logic              EMPTY,
    output logic              FULL,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              mem_we;
    logic [CNT_W-1:0]  mem_waddr;
    logic [CNT_W-1:0]  top_addr;
    logic [DATA_W-1:0] top_data;
    lifo_op_e          op;
    logic              is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign top_addr = count_q - CNT_W'(1);
    assign op       = lifo_op_e'({push, pop});

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (CNT_W)
    ) u_mem (
        .clk   (Clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (dataIn),
        .raddr (top_addr),
        .rdata (top_data)
    );

    // Next-state decode of pointer, read data, strobe and sticky flags.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        count_d   = count_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = count_q;

        if (EN) begin
            // Clear first so an error in the same cycle overrides it.
            if (clr_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            case (op)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        dout_d  = top_data;
                        valid_d = 1'b1;
                        count_d = count_q - CNT_W'(1);
                    end
                end
                OP_SWAP: begin
                    valid_d = 1'b1;
                    if (is_empty) begin
                        // Nothing stored: hand the incoming word straight through.
                        dout_d = dataIn;
                    end else begin
                        dout_d    = top_data;
                        mem_we    = 1'b1;
                        mem_waddr = top_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign dataOut   = dout_q;
    assign valid     = valid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign EMPTY     = is_empty;
    assign FULL      = is_full;

endmodule

// File: doc/lifo_stack_param.md
Name: lifo_stack_param

Overview:
Parametrised successor to the single-channel LIFO buffer register: a synchronous stack of DEPTH words of DATA_W bits. Separate push/pop strobes replace the single RW mode bit, so push and pop can occur in the same cycle. Adds an occupancy count, sticky overflow/underflow flags and a read-valid strobe. Sits between a producer and consumer that need last-in-first-out reordering, e.g. nested-context save/restore.

Parameters:
DATA_W, 4, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, need not be a power of two)
CNT_W, $clog2(DEPTH+1), occupancy count width; derived, never overridden

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  synchronous active-high reset
EN  in  1  global enable; when 0, push/pop/clr_err are ignored
push  in  1  write dataIn onto top of stack
pop  in  1  read and remove top of stack
clr_err  in  1  clear sticky error flags
dataIn  in  DATA_W  write data
dataOut  out  DATA_W  registered read data
valid  out  1  one-cycle strobe: dataOut was updated by a successful pop this cycle
EMPTY  out  1  count == 0
FULL  out  1  count == DEPTH
count  out  CNT_W  current occupancy
overflow  out  1  sticky: a push was dropped because the stack was full
underflow  out  1  sticky: a pop was attempted while empty

Behaviour:
- Reset (Rst=1 at edge, any cycle, overrides everything): count=0, dataOut=0, valid=0, overflow=0, underflow=0; EMPTY=1, FULL=0. Storage contents are don't-care and need not be cleared.
- EMPTY and FULL are combinational decodes of count, with no extra latency.
- Stack pointer sp equals count; the top entry is mem[sp-1]. There is no wrap-around: sp saturates at 0 and DEPTH.
- The following operations apply at the rising edge with EN=1. Pop read latency is 1 cycle: dataOut and valid are registered.
  - push only, not FULL: mem[sp] <= dataIn; count+1.
  - push only, FULL: write dropped; count unchanged; overflow <= 1.
  - pop only, not EMPTY: dataOut <= mem[sp-1]; valid <= 1; count-1.
  - pop only, EMPTY: dataOut holds; valid <= 0; underflow <= 1.
  - push+pop, not EMPTY (FULL included): dataOut <= old top; top entry is overwritten with dataIn; valid <= 1; count unchanged; no flag set.
  - push+pop, EMPTY: bypass. dataOut <= dataIn; valid <= 1; count stays 0; no flag set.
  - neither: state holds; valid <= 0.
- EN=0: no state change except valid <= 0. dataOut holds and flags hold.
- clr_err=1 with EN=1 clears both sticky flags. If an error occurs in the same cycle, the set wins.
- dataOut holds its last popped value until the next successful pop or reset.
- Reset mid-operation discards all entries. The first pop after reset sets underflow.

Decomposition:
- Shared package lifo_pkg holds the op-code enum derived from {push,pop} (OP_IDLE, OP_PUSH, OP_POP, OP_SWAP) and a helper that computes CNT_W from DEPTH.
- One sub-module, lifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one combinational read port. It keeps the pointer/flag control logic separate from storage and can be swapped for inferred RAM later.

Test Plan:
- Reset, then with DEPTH=4, DATA_W=4, push 0x0, 0x2, 0x4, 0x6 -> count 1,2,3,4; FULL=1 after the 4th; EMPTY=0.
- Pop four times from that state -> dataOut 0x6, 0x4, 0x2, 0x0 one cycle after each pop with valid=1; EMPTY=1 after the last; a 5th pop gives valid=0, dataOut stays 0x0, underflow=1.
- FULL with 0x6 on top, push 0x9 -> count stays 4, overflow=1; next pop returns 0x6. Then clr_err=1 -> overflow=0.
- Stack holding {0x3,0x5} (0x5 on top), push+pop with dataIn=0xA -> dataOut=0x5, valid=1, count stays 2; next pop returns 0xA.
- EMPTY, push+pop with dataIn=0x7 -> dataOut=0x7, valid=1, count 0, no flags set. EN=0 with push=1 -> count unchanged.
- Push three words, assert Rst for one cycle while push=1 -> count=0, dataOut=0, flags 0; following pop sets underflow.
